// File: rtl/sample_uart_tx.sv
// sample_uart_tx: FIFO-buffered 8N1 UART transmitter for sample bytes.
// Ports: clk, rst_n (async low); ena gates frame start; data_in/data_valid/
// data_ready push side; tx serial out (idle high); busy frame in progress;
// fifo_count occupancy; overflow sticky drop flag, cleared by clear_ovf.
module sample_uart_tx #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [7:0]               data_in,
    input  logic                     data_valid,
    output logic                     data_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     clear_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tx_q;
    logic          busy_q;
    logic          ovf_q;
    logic          tx_nxt;
    logic          push;
    logic          pop;
    logic          drop;
    logic          last_cyc;

    assign data_ready = (count != (PW+1)'(DEPTH));
    assign push       = data_valid && data_ready;
    assign drop       = data_valid && !data_ready;
    assign pop        = (state == IDLE) && ena && (count != '0);
    assign last_cyc   = (cyc_cnt == CW'(CLKS_PER_BIT - 1));

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count;
    assign overflow   = ovf_q;

    // FIFO storage is not reset; emptiness is carried by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clear_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            // tx and busy are registered copies of the current state's
            // line level, so both trail the FSM by one cycle.
            tx_q   <= tx_nxt;
            busy_q <= (state != IDLE);
            if (state == IDLE) begin
                cyc_cnt <= '0;
                bit_cnt <= '0;
                if (pop) begin
                    shreg <= mem[rd_ptr];
                end
            end else if (last_cyc) begin
                cyc_cnt <= '0;
                if (state == DATA) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
                end
            end else begin
                cyc_cnt <= cyc_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (last_cyc) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx_nxt = shreg[0];
                if (last_cyc && (bit_cnt == 3'd7)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (last_cyc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sample_uart_tx.sv
// tb_sample_uart_tx: randomized scoreboard bench for sample_uart_tx.
// A queue model predicts FIFO/flags and frame start times; a UART decoder checks tx.
module tb_sample_uart_tx;

    localparam int DEPTH = 8;
    localparam int CPB   = 4;

    typedef struct {
        logic [7:0] d;
        int         t;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       clear_ovf = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rst_cnt = 0;
    bit chk_en = 1'b0;

    logic [7:0] m_q[$];
    frame_t     exp_q[$];
    int         m_left = 0;
    logic       m_ovf = 1'b0;
    logic       m_busy = 1'b0;

    sample_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .data_in(data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .tx(tx),
        .busy(busy),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .clear_ovf(clear_ovf)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge rst_n) rst_cnt++;

    // Reference model: FIFO as a queue, transmitter as a 10-bit-time
    // occupancy window, one idle cycle before the next frame may start.
    int         sz;
    logic       m_pop;
    logic       m_push;
    logic       m_drop;
    frame_t     fr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_left = 0;
            m_ovf  = 1'b0;
            m_busy = 1'b0;
        end else begin
            cyc++;
            sz     = m_q.size();
            m_pop  = (m_left == 0) && ena && (sz != 0);
            m_push = data_valid && (sz < DEPTH);
            m_drop = data_valid && (sz == DEPTH);
            m_busy = (m_left != 0);
            if (m_left != 0) m_left--;
            if (m_pop) begin
                fr.d = m_q.pop_front();
                fr.t = cyc + 1;
                exp_q.push_back(fr);
                m_left = 10 * CPB;
            end
            if (m_push) m_q.push_back(data_in);
            if (m_drop) m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("fifo_count", int'(fifo_count), m_q.size());
            check("data_ready", int'(data_ready), int'(m_q.size() != DEPTH));
            check("overflow", int'(overflow), int'(m_ovf));
            check("busy", int'(busy), int'(m_busy));
            if (!m_busy) check("tx_idle", int'(tx), 1);
        end
    end

    // UART receiver: samples mid-bit, compares against scoreboard.
    int         d_t0;
    int         d_rc;
    logic [7:0] d_b;
    logic       d_sb;
    frame_t     d_e;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && rst_n && tx === 1'b0) begin
                d_t0 = cyc;
                d_rc = rst_cnt;
                repeat (CPB + CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    d_b[i] = tx;
                    repeat (CPB) @(negedge clk);
                end
                d_sb = tx;
                if (d_rc == rst_cnt) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL frame_unexpected: got 0x%02h expected none (cycle %0d)",
                                 d_b, d_t0);
                    end else begin
                        d_e = exp_q.pop_front();
                        check("frame_data", int'(d_b), int'(d_e.d));
                        check("frame_start", d_t0, d_e.t);
                        check("stop_bit", int'(d_sb), 1);
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic co);
        @(negedge clk);
        data_valid = v;
        data_in    = d;
        clear_ovf  = co;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((m_q.size() != 0 || exp_q.size() != 0 || m_busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", int'(n < max_cyc), 1);
        idle(4);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(50);

        // single frame
        drive(1'b1, 8'hA5, 1'b0);
        idle(1);
        drain(200);

        // burst overflowing the FIFO, then clear priority
        for (int i = 1; i <= 10; i++) drive(1'b1, 8'(i), 1'b0);
        drive(1'b1, 8'hEE, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        idle(1);
        drain(1000);

        // ena gating
        ena = 1'b0;
        drive(1'b1, 8'h3C, 1'b0);
        drive(1'b1, 8'hC3, 1'b0);
        idle(30);
        ena = 1'b1;
        drain(300);

        // ena dropped mid-frame
        drive(1'b1, 8'h5A, 1'b0);
        drive(1'b1, 8'h77, 1'b0);
        idle(10);
        ena = 1'b0;
        idle(80);
        ena = 1'b1;
        drain(300);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) ena = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 2) == 0), 8'($urandom),
                  ($urandom_range(0, 15) == 0));
        end
        ena = 1'b1;
        idle(1);
        drain(3000);

        // reset during bit 3 of 0x96 with two bytes queued
        drive(1'b1, 8'h96, 1'b0);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        idle(1);
        repeat (16) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_ready", int'(data_ready), 1);
        idle(3);
        rst_n = 1'b1;
        idle(60);
        check("post_rst_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_uart_tx.md
Name: sample_uart_tx

Overview:
- Transmit end of the sample path. Buffers 8-bit converted-voltage samples in a small FIFO and serialises them off-chip as 8N1 UART frames on one pin.
- Lets an external logger read the stream that data_collector produces.
- Sits beside data_collector in the top level. Its tx output drives a bidirectional output pin.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >=2.
- CLKS_PER_BIT, 4, clk cycles per UART bit; >=2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; while low, no new frame starts
- data_in  input  8  sample to enqueue
- data_valid  input  1  enqueue request, sampled on rising clk
- data_ready  output  1  FIFO not full
- tx  output  1  UART serial out, idle high
- busy  output  1  frame in progress
- fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy
- overflow  output  1  sticky: a sample was dropped
- clear_ovf  input  1  clears overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values (applied immediately on rst_n low): tx=1, busy=0, fifo_count=0, overflow=0, data_ready=1. FIFO pointers zeroed, FSM in IDLE, bit and cycle counters cleared.
- Reset mid-frame: the frame is abandoned and buffered data is discarded. tx returns high asynchronously.
- data_ready = (fifo_count != DEPTH), decoded from registered state.
- Push: occurs when data_valid && data_ready.
- Dropped push: data_valid && !data_ready drops the sample and sets overflow on that edge. This applies even if a pop happens in the same cycle.
- overflow remains set until clear_ovf=1. If set and clear occur in the same cycle, set wins.
- Pop: happens only in IDLE, when ena=1 and fifo_count!=0. The head is loaded into an 8-bit shift register.
- fifo_count update per edge: +1 for push only, -1 for pop only, unchanged for push and pop together.
- Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. A pop moves the FSM to START on the next edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Shift right after each bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- busy=1 in START, DATA and STOP.
- tx is registered and glitch-free.
- Latency: a push into an empty FIFO with the FSM in IDLE and ena=1 appears at fifo_count 1 cycle later. IDLE pops on that same cycle. tx falls 2 cycles after the push edge.
- Back-to-back frames: period is 10*CLKS_PER_BIT+1 cycles. The extra cycle is one IDLE cycle with tx high between the stop bit and the next start bit.
- ena dropping mid-frame: the current frame completes. The FSM then waits in IDLE while pushes continue to be accepted.
- Bit and cycle counters are sized $clog2(CLKS_PER_BIT) and 3 bits. They never wrap inside a state.

Test Plan:
- Reset: assert rst_n=0 mid-sim -> tx=1, busy=0, fifo_count=0, overflow=0, data_ready=1. Release, idle 50 cycles -> tx stays 1.
- Single byte 0xA5, CLKS_PER_BIT=4, ena=1: push at cycle 0 -> tx=0 for cycles 2-5. Data bits 1,0,1,0,0,1,0,1 each 4 cycles (cycles 6-37). Stop high cycles 38-41. busy falls at cycle 42.
- Burst: 10 consecutive pushes 0x01..0x0A, DEPTH=8, TX idle -> 0x01 popped at cycle 1. 0x02..0x09 fill the FIFO (fifo_count=8, data_ready=0). 0x0A is dropped and overflow=1. UART decoder receives 0x01..0x09 in order, each frame 41 cycles apart.
- ena gating: ena=0, push 0x3C and 0xC3 -> tx stays 1, fifo_count=2. Raise ena -> 0x3C then 0xC3 transmitted, fifo_count returns to 0.
- Overflow priority: FIFO full, assert data_valid and clear_ovf in the same cycle -> overflow=1. Next cycle, clear_ovf alone -> overflow=0.
- Reset mid-frame: assert rst_n low during bit 3 of 0x96, with 2 more bytes queued -> tx=1 immediately. After release, no frames are sent and fifo_count=0.
